aximm_wr_responder: RTL and testbench
=====================================

// Module: aximm_wr_responder
// PURPOSE
//  AXI4 memory-mapped write responder (slave) that terminates the m_axi_mm_video write channels.
//  Accepts one AW burst at a time, stores the W beats into an internal word RAM and returns one B response per burst.
//  Exposes a 1-cycle-latency side read port so a bench or checker can inspect the written frame data.
//  Sits opposite the data_gen/fifo write master in the aximm_test2 system.
// PARAMETERS
//  ID_WIDTH    1     AWID/BID width
//  ADDR_WIDTH  64    AWADDR width (byte address)
//  DATA_WIDTH  8     WDATA width in bits; multiple of 8; DATA_BYTES = DATA_WIDTH/8
//  MEM_WORDS   4096  RAM depth in DATA_WIDTH words; power of 2; byte capacity = MEM_WORDS*DATA_BYTES
// PORTS
//  ap_clk         in   1           clock; all logic rising-edge
//  ap_rst_n       in   1           reset; asynchronous assert, active-low
//  s_axi_AWVALID  in   1           address valid
//  s_axi_AWREADY  out  1           address ready
//  s_axi_AWADDR   in   ADDR_WIDTH  burst start byte address
//  s_axi_AWID     in   ID_WIDTH    burst ID, echoed on BID
//  s_axi_AWLEN    in   8           beats-1
//  s_axi_AWSIZE   in   3           log2 bytes per beat
//  s_axi_AWBURST  in   2           0=FIXED 1=INCR 2=WRAP
//  s_axi_WVALID   in   1           write data valid
//  s_axi_WREADY   out  1           write data ready
//  s_axi_WDATA    in   DATA_WIDTH  beat data
//  s_axi_WSTRB    in   DATA_BYTES  byte enables
//  s_axi_WLAST    in   1           final beat marker
//  s_axi_BVALID   out  1           response valid
//  s_axi_BREADY   in   1           response ready
//  s_axi_BRESP    out  2           0=OKAY 2=SLVERR
//  s_axi_BID      out  ID_WIDTH    latched AWID
//  mem_rd_addr    in   log2(MEM_WORDS)  side-port word index
//  mem_rd_data    out  DATA_WIDTH  RAM word at mem_rd_addr, registered (1 cycle)
//  bursts_done    out  32          count of B handshakes completed; wraps at 2^32
// BEHAVIOUR
//  Reset: AWREADY=1, WREADY=0, BVALID=0, BRESP=0, BID=0, mem_rd_data=0, bursts_done=0, state=IDLE. RAM contents not reset.
//  FSM IDLE: AWREADY=1. On AWVALID&AWREADY, latch ID, LEN, BURST, word addr = AWADDR>>log2(DATA_BYTES), beat_cnt=0, err=0 -> DATA.
//    err is set at the same edge if AWSIZE!=log2(DATA_BYTES), AWBURST==WRAP or 3, or AWADDR not DATA_BYTES-aligned.
//  FSM DATA: AWREADY=0, WREADY=1. On each WVALID&WREADY beat:
//    - Write the RAM with WSTRB byte enables unless err=1 or word addr >= MEM_WORDS; an out-of-range beat sets err and is dropped.
//    - INCR: addr+=1 per beat. FIXED: addr held.
//    - WLAST != (beat_cnt==LEN) sets err. The burst ends on beat_cnt==LEN regardless of WLAST; then state -> RESP, else beat_cnt++.
//  FSM RESP: WREADY=0. BVALID=1, BRESP = err ? SLVERR : OKAY, BID = latched ID.
//    Hold until BREADY; on handshake BVALID=0, bursts_done++ -> IDLE. AWREADY is reasserted the cycle after the B handshake.
//  Latency: first WREADY one cycle after the AW handshake; BVALID one cycle after the final W handshake.
//  Throughput: one beat per cycle.
//  Address wrap: no wrap at MEM_WORDS. Beats past the end are dropped and produce SLVERR; earlier in-range beats stay written.
//  Side port: reading the address written in the same cycle returns the old data (read-before-write).
//  Reset mid-burst: returns to IDLE immediately, with no B response. Partially written words remain.
//  Outstanding: single burst only. AW presented during DATA/RESP waits (AWREADY=0). W presented in IDLE waits (WREADY=0).
// STRUCTURE
//  aximm_pkg: BURST_FIXED/INCR/WRAP, RESP_OKAY/RESP_SLVERR, state typedef {IDLE,DATA,RESP}.
//  Sub-module dp_ram_be: one write port with byte enables, one registered read port; instantiated once.
//  The responder holds the FSM, the address/beat counters and the B channel registers.
// TESTING
//  1 INCR AW addr=0x10 LEN=3, W 0xA1..0xA4 (WLAST on beat 3), BREADY=1 -> mem[0x10..0x13]=A1..A4, BRESP=OKAY, bursts_done=1.
//  2 FIXED AW addr=0x20 LEN=2, W 0x11,0x22,0x33 -> mem[0x20]=0x33, OKAY; BID equals AWID=1.
//  3 WLAST early on beat 1 of LEN=3 -> all 4 beats accepted; BRESP=SLVERR.
//  4 INCR addr=MEM_WORDS-2 LEN=3 -> last 2 words written, the 2 overflow beats dropped, SLVERR, no RAM aliasing at 0/1.
//  5 BREADY low 5 cycles -> BVALID/BRESP/BID stable, AWREADY=0 throughout; AW accepted on the cycle after the handshake.
//  6 ap_rst_n pulsed low after beat 1 of LEN=7 -> BVALID=0, AWREADY=1 next cycle; a fresh burst then completes OKAY.

Source files
------------

// File: rtl/aximm_pkg.sv
// Shared AXI4 encodings and responder state type for the aximm_test2 write-response path.
package aximm_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_t;

  // Only FIXED and INCR are served; WRAP and the reserved encoding are rejected.
  function automatic logic burst_supported(input logic [1:0] burst);
    return (burst == BURST_FIXED) || (burst == BURST_INCR);
  endfunction

endpackage

// File: rtl/dp_ram_be.sv
// Word RAM with one byte-enabled write port and one registered read port (read-before-write).
module dp_ram_be #(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_WORDS  = 4096
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         we,
  input  logic [$clog2(MEM_WORDS)-1:0] waddr,
  input  logic [DATA_WIDTH/8-1:0]      wstrb,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic [$clog2(MEM_WORDS)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]        rdata
);

  localparam int BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_r [MEM_WORDS];
  logic [DATA_WIDTH-1:0] rdata_r;

  // Storage array is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wstrb[b]) begin
          mem_r[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= {DATA_WIDTH{1'b0}};
    end else begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/aximm_wr_responder.sv
// AXI4 write slave terminating m_axi_mm_video: one burst at a time into a word RAM,
// one B response per burst, plus a registered side read port for inspection.
module aximm_wr_responder
  import aximm_pkg::*;
#(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_WORDS  = 4096
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         s_axi_AWVALID,
  output logic                         s_axi_AWREADY,
  input  logic [ADDR_WIDTH-1:0]        s_axi_AWADDR,
  input  logic [ID_WIDTH-1:0]          s_axi_AWID,
  input  logic [7:0]                   s_axi_AWLEN,
  input  logic [2:0]                   s_axi_AWSIZE,
  input  logic [1:0]                   s_axi_AWBURST,
  input  logic                         s_axi_WVALID,
  output logic                         s_axi_WREADY,
  input  logic [DATA_WIDTH-1:0]        s_axi_WDATA,
  input  logic [DATA_WIDTH/8-1:0]      s_axi_WSTRB,
  input  logic                         s_axi_WLAST,
  output logic                         s_axi_BVALID,
  input  logic                         s_axi_BREADY,
  output logic [1:0]                   s_axi_BRESP,
  output logic [ID_WIDTH-1:0]          s_axi_BID,
  input  logic [$clog2(MEM_WORDS)-1:0] mem_rd_addr,
  output logic [DATA_WIDTH-1:0]        mem_rd_data,
  output logic [31:0]                  bursts_done
);

  localparam int DATA_BYTES = DATA_WIDTH / 8;
  localparam int ADDR_LSB   = $clog2(DATA_BYTES);
  localparam int MEM_AW     = $clog2(MEM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(DATA_BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] MEM_LIMIT  = ADDR_WIDTH'(MEM_WORDS);
  localparam logic [2:0]            BEAT_SIZE  = 3'(ADDR_LSB);

  state_t                state_r, state_nxt_s;
  logic [ID_WIDTH-1:0]   id_r;
  logic [7:0]            len_r;
  logic [1:0]            burst_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [7:0]            beat_cnt_r;
  logic                  err_r;

  logic                  awready_r, wready_r, bvalid_r;
  logic [1:0]            bresp_r;
  logic [ID_WIDTH-1:0]   bid_r;
  logic [31:0]           bursts_done_r;

  logic aw_hs_s, w_hs_s, b_hs_s;
  logic beat_last_s, beat_oob_s, beat_err_s, aw_err_s, ram_we_s;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  always_comb begin
    state_nxt_s = state_r;
    aw_hs_s     = 1'b0;
    w_hs_s      = 1'b0;
    b_hs_s      = 1'b0;
    ram_we_s    = 1'b0;
    beat_err_s  = 1'b0;
    beat_last_s = (beat_cnt_r == len_r);
    beat_oob_s  = (addr_r >= MEM_LIMIT);
    aw_err_s    = (s_axi_AWSIZE != BEAT_SIZE) || !burst_supported(s_axi_AWBURST) ||
                  ((s_axi_AWADDR & ALIGN_MASK) != {ADDR_WIDTH{1'b0}});
    case (state_r)
      IDLE: begin
        aw_hs_s = s_axi_AWVALID && awready_r;
        if (aw_hs_s) begin
          state_nxt_s = DATA;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DATA: begin
        w_hs_s = s_axi_WVALID && wready_r;
        if (w_hs_s) begin
          // A beat past the RAM end is dropped; the burst length alone decides completion.
          ram_we_s   = !err_r && !beat_oob_s;
          beat_err_s = beat_oob_s || (s_axi_WLAST != beat_last_s);
          if (beat_last_s) begin
            state_nxt_s = RESP;
          end else begin
            state_nxt_s = DATA;
          end
        end else begin
          state_nxt_s = DATA;
        end
      end
      RESP: begin
        b_hs_s = bvalid_r && s_axi_BREADY;
        if (b_hs_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      id_r       <= {ID_WIDTH{1'b0}};
      len_r      <= 8'd0;
      burst_r    <= BURST_FIXED;
      addr_r     <= {ADDR_WIDTH{1'b0}};
      beat_cnt_r <= 8'd0;
      err_r      <= 1'b0;
    end else if (aw_hs_s) begin
      id_r       <= s_axi_AWID;
      len_r      <= s_axi_AWLEN;
      burst_r    <= s_axi_AWBURST;
      addr_r     <= s_axi_AWADDR >> ADDR_LSB;
      beat_cnt_r <= 8'd0;
      err_r      <= aw_err_s;
    end else if (w_hs_s) begin
      err_r <= err_r | beat_err_s;
      if (burst_r == BURST_INCR) begin
        addr_r <= addr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      end
      if (!beat_last_s) begin
        beat_cnt_r <= beat_cnt_r + 8'd1;
      end
    end
  end

  // Handshake outputs are registered from the next state so they align with it.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      awready_r     <= 1'b1;
      wready_r      <= 1'b0;
      bvalid_r      <= 1'b0;
      bresp_r       <= RESP_OKAY;
      bid_r         <= {ID_WIDTH{1'b0}};
      bursts_done_r <= 32'd0;
    end else begin
      awready_r <= (state_nxt_s == IDLE);
      wready_r  <= (state_nxt_s == DATA);
      bvalid_r  <= (state_nxt_s == RESP);
      if (w_hs_s && beat_last_s) begin
        bresp_r <= (err_r || beat_err_s) ? RESP_SLVERR : RESP_OKAY;
        bid_r   <= id_r;
      end
      if (b_hs_s) begin
        bursts_done_r <= bursts_done_r + 32'd1;
      end
    end
  end

  dp_ram_be #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_WORDS  (MEM_WORDS)
  ) u_ram (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .we    (ram_we_s),
    .waddr (addr_r[MEM_AW-1:0]),
    .wstrb (s_axi_WSTRB),
    .wdata (s_axi_WDATA),
    .raddr (mem_rd_addr),
    .rdata (mem_rd_data)
  );

  assign s_axi_AWREADY = awready_r;
  assign s_axi_WREADY  = wready_r;
  assign s_axi_BVALID  = bvalid_r;
  assign s_axi_BRESP   = bresp_r;
  assign s_axi_BID     = bid_r;
  assign bursts_done   = bursts_done_r;

endmodule

// File: tb/tb_aximm_wr_responder.sv
// Randomized self-checking bench for aximm_wr_responder against a burst-level memory model.
module tb_aximm_wr_responder;

  localparam int MW = 4096;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        s_axi_AWVALID, s_axi_AWREADY;
  logic [63:0] s_axi_AWADDR;
  logic [0:0]  s_axi_AWID;
  logic [7:0]  s_axi_AWLEN;
  logic [2:0]  s_axi_AWSIZE;
  logic [1:0]  s_axi_AWBURST;
  logic        s_axi_WVALID, s_axi_WREADY;
  logic [7:0]  s_axi_WDATA;
  logic [0:0]  s_axi_WSTRB;
  logic        s_axi_WLAST;
  logic        s_axi_BVALID, s_axi_BREADY;
  logic [1:0]  s_axi_BRESP;
  logic [0:0]  s_axi_BID;
  logic [11:0] mem_rd_addr;
  logic [7:0]  mem_rd_data;
  logic [31:0] bursts_done;

  always #5 ap_clk = ~ap_clk;

  aximm_wr_responder dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_axi_AWVALID(s_axi_AWVALID), .s_axi_AWREADY(s_axi_AWREADY), .s_axi_AWADDR(s_axi_AWADDR),
    .s_axi_AWID(s_axi_AWID), .s_axi_AWLEN(s_axi_AWLEN), .s_axi_AWSIZE(s_axi_AWSIZE),
    .s_axi_AWBURST(s_axi_AWBURST), .s_axi_WVALID(s_axi_WVALID), .s_axi_WREADY(s_axi_WREADY),
    .s_axi_WDATA(s_axi_WDATA), .s_axi_WSTRB(s_axi_WSTRB), .s_axi_WLAST(s_axi_WLAST),
    .s_axi_BVALID(s_axi_BVALID), .s_axi_BREADY(s_axi_BREADY), .s_axi_BRESP(s_axi_BRESP),
    .s_axi_BID(s_axi_BID), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .bursts_done(bursts_done)
  );

  int checks = 0;
  int failures = 0;
  int exp_done = 0;
  logic [7:0] ref_mem [MW];
  bit         known   [MW];
  logic [7:0] bd [256];
  logic       bs [256];
  logic       bl [256];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Burst-level reference: apply the first nbeats beats to ref_mem, return the expected BRESP.
  task automatic model_burst(input longint addr, input int len, input int size, input int burst,
                             input int nbeats, output logic [1:0] resp);
    bit err;
    longint w;
    err = (size != 0) || (burst > 1);
    for (int i = 0; i < nbeats; i++) begin
      w = (burst == 1) ? addr + i : addr;
      if (w >= MW) err = 1;
      else if (!err && bs[i]) begin
        ref_mem[w] = bd[i];
        known[w] = 1;
      end
      if (bl[i] != (i == len)) err = 1;
    end
    resp = err ? 2'b10 : 2'b00;
  endtask

  task automatic send_aw(input longint addr, input int id, input int len, input int size, input int burst);
    int n;
    @(negedge ap_clk);
    s_axi_AWADDR = addr; s_axi_AWID = id[0:0]; s_axi_AWLEN = len[7:0];
    s_axi_AWSIZE = size[2:0]; s_axi_AWBURST = burst[1:0]; s_axi_AWVALID = 1'b1;
    n = 0;
    while (!s_axi_AWREADY && n < 50) begin @(negedge ap_clk); n++; end
    if (s_axi_AWREADY) @(posedge ap_clk);
    else chk("aw_timeout", s_axi_AWREADY, 1);
    #1 s_axi_AWVALID = 1'b0;
  endtask

  task automatic send_beats(input int first, input int last, input bit gaps);
    int n;
    for (int i = first; i <= last; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(negedge ap_clk);
        s_axi_WVALID = 1'b0;
      end
      @(negedge ap_clk);
      s_axi_WVALID = 1'b1; s_axi_WDATA = bd[i]; s_axi_WSTRB = bs[i]; s_axi_WLAST = bl[i];
      n = 0;
      while (!s_axi_WREADY && n < 50) begin @(negedge ap_clk); n++; end
      if (s_axi_WREADY) begin
        chk("aw_blocked_in_data", s_axi_AWREADY, 0);
        @(posedge ap_clk);
      end else chk("w_timeout", s_axi_WREADY, 1);
    end
    @(negedge ap_clk);
    s_axi_WVALID = 1'b0; s_axi_WLAST = 1'b0;
  endtask

  task automatic get_b(input logic [1:0] exp_resp, input int exp_id, input int hold);
    int n;
    n = 0;
    while (!s_axi_BVALID && n < 50) begin @(negedge ap_clk); n++; end
    if (!s_axi_BVALID) begin
      chk("b_timeout", s_axi_BVALID, 1);
      return;
    end
    chk("bresp", s_axi_BRESP, exp_resp);
    chk("bid", s_axi_BID, exp_id[0:0]);
    for (int k = 0; k < hold; k++) begin
      @(negedge ap_clk);
      chk("bvalid_hold", s_axi_BVALID, 1);
      chk("bresp_hold", s_axi_BRESP, exp_resp);
      chk("bid_hold", s_axi_BID, exp_id[0:0]);
      chk("awready_in_resp", s_axi_AWREADY, 0);
    end
    s_axi_BREADY = 1'b1;
    @(posedge ap_clk);
    #1 s_axi_BREADY = 1'b0;
    exp_done++;
    @(negedge ap_clk);
    chk("awready_after_b", s_axi_AWREADY, 1);
    chk("bvalid_after_b", s_axi_BVALID, 0);
    chk("bursts_done", bursts_done, exp_done);
  endtask

  task automatic rd(input int a, output logic [7:0] d);
    @(negedge ap_clk);
    mem_rd_addr = a[11:0];
    @(posedge ap_clk);
    #1 d = mem_rd_data;
  endtask

  task automatic chk_word(input int a);
    logic [7:0] d;
    if (known[a]) begin
      rd(a, d);
      chk($sformatf("mem[%0h]", a), d, ref_mem[a]);
    end
  endtask

  task automatic burst(input longint addr, input int id, input int len, input int size,
                       input int btype, input int hold, input bit gaps);
    logic [1:0] er;
    model_burst(addr, len, size, btype, len + 1, er);
    send_aw(addr, id, len, size, btype);
    send_beats(0, len, gaps);
    get_b(er, id, hold);
  endtask

  initial begin
    logic [7:0] d, old;
    logic [1:0] er;
    longint a;
    int len, bt, k;
    for (int i = 0; i < MW; i++) known[i] = 0;
    ap_rst_n = 1'b0; s_axi_AWVALID = 1'b0; s_axi_AWADDR = 64'd0; s_axi_AWID = 1'b0;
    s_axi_AWLEN = 8'd0; s_axi_AWSIZE = 3'd0; s_axi_AWBURST = 2'd0; s_axi_WVALID = 1'b0;
    s_axi_WDATA = 8'd0; s_axi_WSTRB = 1'b0; s_axi_WLAST = 1'b0; s_axi_BREADY = 1'b0;
    mem_rd_addr = 12'd0;
    repeat (3) @(negedge ap_clk);
    chk("rst_awready", s_axi_AWREADY, 1);
    chk("rst_wready", s_axi_WREADY, 0);
    chk("rst_bvalid", s_axi_BVALID, 0);
    chk("rst_bresp", s_axi_BRESP, 0);
    chk("rst_bid", s_axi_BID, 0);
    chk("rst_rd_data", mem_rd_data, 0);
    chk("rst_bursts_done", bursts_done, 0);
    ap_rst_n = 1'b1;

    // 1: INCR 0x10 LEN=3
    for (int i = 0; i < 4; i++) begin bd[i] = 8'hA1 + 8'(i); bs[i] = 1'b1; bl[i] = (i == 3); end
    burst(64'h10, 0, 3, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      rd(16 + i, d);
      chk("t1_mem", d, 8'hA1 + 8'(i));
    end

    // 2: W waits in IDLE, then FIXED 0x20 LEN=2 ID=1
    @(negedge ap_clk);
    s_axi_WVALID = 1'b1;
    repeat (3) begin @(negedge ap_clk); chk("wready_idle", s_axi_WREADY, 0); end
    s_axi_WVALID = 1'b0;
    bd[0] = 8'h11; bd[1] = 8'h22; bd[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin bs[i] = 1'b1; bl[i] = (i == 2); end
    burst(64'h20, 1, 2, 0, 0, 0, 0);
    rd(32, d);
    chk("t2_fixed", d, 8'h33);

    // 3: early WLAST on beat 1 of LEN=3
    for (int i = 0; i < 4; i++) begin bd[i] = 8'hC0 + 8'(i); bs[i] = 1'b1; bl[i] = (i == 1) || (i == 3); end
    burst(64'h30, 0, 3, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) chk_word(48 + i);

    // 4: overflow past the RAM end, with words 0/1 as aliasing sentinels
    bd[0] = 8'h5C; bd[1] = 8'h5D; bs[0] = 1'b1; bs[1] = 1'b1; bl[0] = 1'b0; bl[1] = 1'b1;
    burst(64'h0, 0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin bd[i] = 8'hE0 + 8'(i); bs[i] = 1'b1; bl[i] = (i == 3); end
    burst(MW - 2, 1, 3, 0, 1, 0, 0);
    rd(MW - 2, d); chk("t4_last2", d, 8'hE0);
    rd(MW - 1, d); chk("t4_last1", d, 8'hE1);
    rd(0, d); chk("t4_alias0", d, 8'h5C);
    rd(1, d); chk("t4_alias1", d, 8'h5D);

    // 5: BREADY held low for 5 cycles
    bd[0] = 8'h77; bs[0] = 1'b1; bl[0] = 1'b1;
    burst(64'h50, 1, 0, 0, 1, 5, 0);

    // Side port returns the old word when read and written in the same cycle
    bd[0] = 8'h5A; bs[0] = 1'b1; bl[0] = 1'b1;
    old = ref_mem[16];
    model_burst(64'h10, 0, 0, 0, 1, er);
    send_aw(64'h10, 0, 0, 0, 0);
    @(negedge ap_clk);
    mem_rd_addr = 12'h010; s_axi_WVALID = 1'b1; s_axi_WDATA = 8'h5A; s_axi_WSTRB = 1'b1; s_axi_WLAST = 1'b1;
    @(posedge ap_clk);
    #1 chk("rd_before_wr", mem_rd_data, old);
    s_axi_WVALID = 1'b0; s_axi_WLAST = 1'b0;
    get_b(er, 0, 0);
    chk_word(16);

    // 6: reset after beat 1 of LEN=7
    for (int i = 0; i < 8; i++) begin bd[i] = 8'h90 + 8'(i); bs[i] = 1'b1; bl[i] = (i == 7); end
    model_burst(64'h40, 7, 0, 1, 2, er);
    send_aw(64'h40, 1, 7, 0, 1);
    send_beats(0, 1, 0);
    ap_rst_n = 1'b0;
    @(posedge ap_clk);
    #1;
    chk("t6_bvalid", s_axi_BVALID, 0);
    chk("t6_awready", s_axi_AWREADY, 1);
    chk("t6_wready", s_axi_WREADY, 0);
    chk("t6_done_reset", bursts_done, 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    exp_done = 0;
    bd[0] = 8'h61; bd[1] = 8'h62; bs[0] = 1'b1; bs[1] = 1'b1; bl[0] = 1'b0; bl[1] = 1'b1;
    burst(64'h48, 0, 1, 0, 1, 0, 0);
    chk_word(64); chk_word(65); chk_word(72); chk_word(73);

    // Randomized bursts
    for (int t = 0; t < 40; t++) begin
      k = $urandom_range(0, 9);
      if (k == 0) a = MW - $urandom_range(1, 6);
      else if (k == 1) a = MW + $urandom_range(0, 100);
      else a = $urandom_range(0, MW - 17);
      len = $urandom_range(0, 15);
      k = $urandom_range(0, 9);
      bt = (k == 0) ? 2 : (k == 1) ? 3 : (k <= 4) ? 0 : 1;
      for (int i = 0; i <= len; i++) begin
        bd[i] = 8'($urandom); bs[i] = ($urandom_range(0, 5) != 0); bl[i] = (i == len);
      end
      if ($urandom_range(0, 7) == 0) begin
        k = $urandom_range(0, len);
        bl[k] = ~bl[k];
      end
      burst(a, $urandom_range(0, 1), len, ($urandom_range(0, 9) == 0) ? 1 : 0, bt,
            $urandom_range(0, 3), 1);
      if (a < MW) chk_word(int'(a));
    end
    for (int i = 0; i < MW; i++) chk_word(i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
